// File: rtl/cnna_mul_share_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared unsigned multiplier.
// The result is tagged with the index of the requester that issued the operands.
module cnna_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 13,
  parameter int B_WIDTH  = 22,
  parameter int P_WIDTH  = 35
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [P_WIDTH-1:0]           res_p,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic                         idle
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                v1_q, v1_d;
  logic [A_WIDTH-1:0]  a1_q, a1_d;
  logic [B_WIDTH-1:0]  b1_q, b1_d;
  logic [ID_WIDTH-1:0] id1_q, id1_d;
  logic                v2_q, v2_d;
  logic [P_WIDTH-1:0]  p2_q, p2_d;
  logic [ID_WIDTH-1:0] id2_q, id2_d;

  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    scan_idx;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;
  logic                adv1, adv2, take;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = {PTR_W{1'b0}};
    scan_sum  = {(PTR_W + 1){1'b0}};
    scan_idx  = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end else begin
        scan_sum = scan_sum;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end else begin
        gnt_found = gnt_found;
      end
    end
  end

  // Operand mux for the granted requester (kept off the req_ready path).
  always_comb begin
    a_sel = {A_WIDTH{1'b0}};
    b_sel = {B_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == gnt_idx) begin
        a_sel = req_a[k*A_WIDTH +: A_WIDTH];
        b_sel = req_b[k*B_WIDTH +: B_WIDTH];
      end else begin
        a_sel = a_sel;
      end
    end
  end

  // Pipeline advance, grant vector and next-state for both stages.
  always_comb begin
    adv2      = !v2_q || res_ready;
    adv1      = !v1_q || adv2;
    take      = adv1 && gnt_found && !ap_rst;
    req_ready = {NUM_REQ{1'b0}};
    rr_ptr_d  = rr_ptr_q;
    v1_d      = v1_q;
    a1_d      = a1_q;
    b1_d      = b1_q;
    id1_d     = id1_q;
    v2_d      = v2_q;
    p2_d      = p2_q;
    id2_d     = id2_q;
    if (take) begin
      req_ready[gnt_idx] = 1'b1;
      v1_d     = 1'b1;
      a1_d     = a_sel;
      b1_d     = b_sel;
      id1_d    = ID_WIDTH'(gnt_idx);
      rr_ptr_d = (gnt_idx == LAST_IDX) ? {PTR_W{1'b0}} : gnt_idx + PTR_W'(1);
    end else if (adv1) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
    if (adv2) begin
      v2_d  = v1_q;
      p2_d  = P_WIDTH'(a1_q) * P_WIDTH'(b1_q);
      id2_d = id1_q;
    end else begin
      v2_d = v2_q;
    end
  end

  // State registers with synchronous reset that drops any in-flight work.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_q <= {PTR_W{1'b0}};
      v1_q     <= 1'b0;
      a1_q     <= {A_WIDTH{1'b0}};
      b1_q     <= {B_WIDTH{1'b0}};
      id1_q    <= {ID_WIDTH{1'b0}};
      v2_q     <= 1'b0;
      p2_q     <= {P_WIDTH{1'b0}};
      id2_q    <= {ID_WIDTH{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      p2_q     <= p2_d;
      id2_q    <= id2_d;
    end
  end

  assign res_valid = v2_q;
  assign res_p     = p2_q;
  assign res_id    = id2_q;
  assign idle      = !v1_q && !v2_q && (req_valid == {NUM_REQ{1'b0}});

endmodule

// File: tb/tb_cnna_mul_share_arb.sv
// Directed and randomized bench for cnna_mul_share_arb against a queue-based reference model.
module tb_cnna_mul_share_arb;

  localparam int N = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*13-1:0] req_a;
  logic [N*22-1:0] req_b;
  logic          res_valid, res_ready;
  logic [34:0]   res_p;
  logic [1:0]    res_id;
  logic          idle;

  cnna_mul_share_arb dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .res_id(res_id), .idle(idle)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          id;
    logic [63:0] p;
    bit          in_s2;
  } item_t;

  item_t       q[$];
  int          ptr_m = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_grant = 0;
  int          fair_lim = 3;
  int          wait_cnt[N];
  logic [N-1:0] rv;
  logic [12:0] a_arr[N];
  logic [21:0] b_arr[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    rv[i]       = 1'b1;
    a_arr[i]    = 13'($urandom);
    b_arr[i]    = 22'($urandom);
    wait_cnt[i] = 0;
  endtask

  // One clock: drive, compare against model, advance model at the edge.
  task automatic cycle();
    bit   s1occ, exp_rv, stall;
    int   g;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      req_a[i*13 +: 13] = a_arr[i];
      req_b[i*22 +: 22] = b_arr[i];
    end
    req_valid = rv;
    #1;
    exp_rv = (q.size() > 0) && q[0].in_s2;
    s1occ  = (q.size() == 2) || (q.size() == 1 && !q[0].in_s2);
    stall  = exp_rv && !res_ready;
    g = -1;
    if (!ap_rst && !(s1occ && stall)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("res_valid", 64'(res_valid), 64'(exp_rv));
    chk("idle", 64'(idle), 64'((q.size() == 0) && (rv == '0)));
    if (exp_rv) begin
      chk("res_p", 64'(res_p), q[0].p);
      chk("res_id", 64'(res_id), 64'(q[0].id));
    end
    @(posedge ap_clk);
    if (ap_rst) begin
      q.delete();
      ptr_m = 0;
    end else begin
      if (!stall) begin
        if (exp_rv && res_ready) void'(q.pop_front());
        foreach (q[i]) q[i].in_s2 = 1'b1;
      end
      if (g >= 0) begin
        chk("fairness", 64'(wait_cnt[g] <= fair_lim), 64'd1);
        for (int i = 0; i < N; i++) if (rv[i] && i != g) wait_cnt[i]++;
        wait_cnt[g] = 0;
        q.push_back('{g, 64'(a_arr[g]) * 64'(b_arr[g]), 1'b0});
        ptr_m = (g + 1) % N;
        rv[g] = 1'b0;
        n_grant++;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_p", 64'(res_p), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
  endtask

  initial begin
    ap_rst = 1'b1; res_ready = 1'b1; rv = '0;
    for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; wait_cnt[i] = 0; end
    req_valid = '0; req_a = '0; req_b = '0;
    @(posedge ap_clk); @(posedge ap_clk); @(negedge ap_clk);
    #1;
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_res_p", 64'(res_p), 64'd0);
    chk("reset_res_id", 64'(res_id), 64'd0);
    chk("reset_idle", 64'(idle), 64'd1);
    rv = 4'hF;
    #1;
    chk("reset_ready_forced0", 64'(req_ready), 64'd0);
    rv = '0;
    ap_rst = 1'b0;

    // Single request 3*5 from requester 0.
    rv[0] = 1'b1; a_arr[0] = 13'd3; b_arr[0] = 22'd5;
    cycle();
    cycle();
    #1;
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_p", 64'(res_p), 64'd15);
    chk("t1_id", 64'(res_id), 64'd0);
    cycle();
    #1;
    chk("t1_idle", 64'(idle), 64'd1);

    // All requesters continuously valid.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!rv[i]) new_req(i);
      cycle();
    end
    rv = '0;
    repeat (3) cycle();

    // Maximum operands on requester 2.
    rv[2] = 1'b1; a_arr[2] = 13'd8191; b_arr[2] = 22'd4194303;
    cycle();
    cycle();
    #1;
    chk("max_p", 64'(res_p), 64'h7FFBFE001);
    chk("max_id", 64'(res_id), 64'd2);
    cycle();

    // Backpressure with requesters 1 and 3.
    do_reset();
    new_req(1); new_req(3);
    n_grant = 0;
    cycle();
    res_ready = 1'b0;
    repeat (4) cycle();
    chk("bp_accepts", 64'(n_grant), 64'd2);
    res_ready = 1'b1;
    repeat (4) cycle();
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset while both stages hold work.
    for (int i = 0; i < N; i++) new_req(i);
    cycle(); cycle();
    rv = '0; new_req(2); new_req(0);
    res_ready = 1'b0;
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0; res_ready = 1'b1;
    #1;
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_grant0", 64'(req_ready), 64'd1);
    repeat (5) cycle();

    // Requester 0 continuous, requester 1 intermittent.
    rv = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    fair_lim = 1;
    for (int c = 0; c < 200; c++) begin
      if (!rv[0]) new_req(0);
      if (!rv[1] && $urandom_range(0, 99) < 30) new_req(1);
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Fully random traffic and backpressure.
    fair_lim = 3;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(0, 99) < 40) new_req(i);
      res_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) ap_rst = 1'b1;
      cycle();
      ap_rst = 1'b0;
    end
    rv = '0; res_ready = 1'b1;
    repeat (4) cycle();
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
